wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Parametrised writeback stage for the LoongArch pipeline. It replaces the fixed three-way writeback select.
- Registers MEM-stage results into a WB pipeline register, with stall and flush.
- Selects among NUM_SRC result sources. The memory source passes through a load byte/half aligner with sign or zero extension.
- Drives the register-file write port and the WB→EX forwarding path, and keeps a retired-instruction counter.

Parameters:
- DW, 32, datapath width; the load aligner requires DW=32 (elaboration error otherwise)
- NUM_SRC, 4, number of writeback sources (minimum 3)
- SEL_W, $clog2(NUM_SRC), width of the source select
- AW, 5, register-file address width
- LINK_OFFSET, 4, constant added to the PC source (link address)
- CNT_W, 32, retired-instruction counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  MEM stage presents an instruction
- in_ready  out  1  stage accepts; equals !wb_stall
- wb_stall  in  1  hold WB register contents
- flush  in  1  kill the instruction being captured and the one held
- wd_sel  in  SEL_W  writeback source index
- src_data  in  NUM_SRC*DW  flattened sources; slice i = src_data[i*DW +: DW]
- ld_type  in  3  load format: 0 W, 1 B signed, 2 H signed, 3 BU, 4 HU, others W
- ld_addr_lo  in  2  load address bits [1:0]
- rd  in  AW  destination register
- rf_we_in  in  1  instruction writes a register
- rf_we  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- fwd_valid  out  1  forwarding entry valid; equals rf_we
- fwd_rd  out  AW  forwarding register; equals rf_waddr
- fwd_data  out  DW  forwarding data; equals rf_wdata
- retire_cnt  out  CNT_W  count of valid instructions retired

Behaviour:
- Source map:
  - index 0 is ALU: pass-through.
  - index 1 is MEM: passes through the aligner.
  - index 2 is PC: outputs src + LINK_OFFSET, modulo 2^DW.
  - index 3 and up: pass-through.
  - Any wd_sel ≥ NUM_SRC gives data 0 and forces write enable to 0.
- Selection and alignment are combinational on the inputs. The selected, final data is registered, so latency is exactly 1 cycle from capture to rf_* outputs.
- Capture occurs when in_valid && in_ready && !flush. The register then loads valid=1, we=rf_we_in && (rd!=0) && sel in range, addr=rd, data=selected.
- No capture and no stall (in_valid=0 or flush): the register loads valid=0, we=0. addr and data hold their previous values.
- wb_stall=1 with flush=0: all register fields hold. rf_we stays asserted if it was set, because the write is idempotent.
- Flush has priority over both stall and capture: valid and we clear on the next edge.
- Aligner:
  - Byte lane = ld_addr_lo.
  - Half lane = ld_addr_lo[1]; ld_addr_lo[0] is ignored for halves.
  - B and H sign-extend; BU and HU zero-extend.
- retire_cnt increments by 1 on every edge where the register holds valid=1 and is not being held by a stall. Each instruction is therefore counted once. The counter wraps from 2^CNT_W-1 to 0.
- Reset, synchronous with priority over all other inputs: valid=0, rf_we=0, rf_waddr=0, rf_wdata=0, retire_cnt=0.
- Reset mid-stall or mid-flush discards the held instruction.
- in_ready is combinational (!wb_stall) and is 1 during reset.

Decomposition:
- Shared package wb_pkg holds:
  - source indices WDSEL_ALU=0, WDSEL_MEM=1, WDSEL_PC=2, WDSEL_CSR=3
  - ld_type encodings LD_W, LD_B, LD_H, LD_BU, LD_HU
- One combinational sub-module, load_align, with inputs raw word, ld_type and ld_addr_lo and output aligned word.
- The select, register and counter stay in wb_select_stage.

Test Plan:
- ALU path: wd_sel=0, src0=0x1234_5678, rd=5, rf_we_in=1 → next cycle rf_we=1, waddr=5, wdata=0x1234_5678; retire_cnt 0→1 the cycle after.
- Load align: MEM word 0x80FF_7F01.
  - LD_B, lo=3 → 0xFFFF_FF80.
  - LD_BU, lo=2 → 0x0000_00FF.
  - LD_H, lo=2 → 0xFFFF_80FF.
  - LD_HU, lo=1 → 0x0000_7F01.
- Link: wd_sel=2, pc=0x1C00_0FFC → wdata=0x1C00_1000; pc=0xFFFF_FFFC → wdata=0x0000_0000.
- r0 and invalid sel:
  - rd=0 → rf_we=0, retire_cnt still increments.
  - NUM_SRC=3 with wd_sel=3 → rf_we=0, wdata=0.
- Stall then flush: capture rd=7; hold wb_stall=1 for 3 cycles → outputs constant, retire_cnt +1 total. Then flush=1 with stall=1 → rf_we=0 next cycle.
- Reset mid-operation: rst=1 while valid and stalled → next edge all outputs 0, retire_cnt=0. Counter with CNT_W=4 after 16 retirements wraps to 0.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback select stage: source indices and
// load-format encodings.
package wb_pkg;

    // Writeback source indices.
    localparam int WDSEL_ALU = 0;
    localparam int WDSEL_MEM = 1;
    localparam int WDSEL_PC  = 2;
    localparam int WDSEL_CSR = 3;

    // Load formats; any encoding not listed behaves as a full word.
    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_H  = 3'd2;
    localparam logic [2:0] LD_BU = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

endpackage

// File: rtl/load_align.sv
// Load byte/half aligner: picks the addressed lane out of a 32-bit memory
// word and sign- or zero-extends it to the full word.
module load_align
    import wb_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  ld_type,
    input  logic [1:0]  ld_addr_lo,
    output logic [31:0] aligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Lane extraction: bytes use both address bits, halves only bit 1.
    always_comb begin
        w_byte = raw[7:0];
        case (ld_addr_lo)
            2'd0: w_byte = raw[7:0];
            2'd1: w_byte = raw[15:8];
            2'd2: w_byte = raw[23:16];
            2'd3: w_byte = raw[31:24];
            default: w_byte = raw[7:0];
        endcase
        w_half = ld_addr_lo[1] ? raw[31:16] : raw[15:0];
    end

    // Extension according to the load format.
    always_comb begin
        aligned = raw;
        case (ld_type)
            LD_B:    aligned = {{24{w_byte[7]}}, w_byte};
            LD_H:    aligned = {{16{w_half[15]}}, w_half};
            LD_BU:   aligned = {24'd0, w_byte};
            LD_HU:   aligned = {16'd0, w_half};
            default: aligned = raw;
        endcase
    end

endmodule

// File: rtl/wb_select_stage.sv
// Writeback stage: selects one of NUM_SRC result sources, registers it into
// the WB pipeline register (stall/flush aware), drives the register-file
// write port plus the WB->EX forwarding path, and counts retirements.
module wb_select_stage
    import wb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int NUM_SRC     = 4,
    parameter int SEL_W       = $clog2(NUM_SRC),
    parameter int AW          = 5,
    parameter int LINK_OFFSET = 4,
    parameter int CNT_W       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  wb_stall,
    input  logic                  flush,
    input  logic [SEL_W-1:0]      wd_sel,
    input  logic [NUM_SRC*DW-1:0] src_data,
    input  logic [2:0]            ld_type,
    input  logic [1:0]            ld_addr_lo,
    input  logic [AW-1:0]         rd,
    input  logic                  rf_we_in,
    output logic                  rf_we,
    output logic [AW-1:0]         rf_waddr,
    output logic [DW-1:0]         rf_wdata,
    output logic                  fwd_valid,
    output logic [AW-1:0]         fwd_rd,
    output logic [DW-1:0]         fwd_data,
    output logic [CNT_W-1:0]      retire_cnt
);

    // Parameter sanity: the aligner is 32-bit only, and sources 0..2 are fixed.
    generate
        if (DW != 32) begin : g_dw_check
            $error("wb_select_stage: load aligner requires DW == 32");
        end
        if (NUM_SRC < 3) begin : g_src_check
            $error("wb_select_stage: NUM_SRC must be at least 3");
        end
    endgenerate

    logic [DW-1:0] w_aligned;
    logic [DW-1:0] w_src_fin [NUM_SRC];
    logic [DW-1:0] w_sel_data;
    logic          w_sel_ok;
    logic          w_capture;
    logic          w_hold;

    logic          r_valid;
    logic          r_we;
    logic [AW-1:0] r_waddr;
    logic [DW-1:0] r_wdata;
    logic [CNT_W-1:0] r_cnt;

    load_align u_align (
        .raw        (src_data[WDSEL_MEM*DW +: DW]),
        .ld_type    (ld_type),
        .ld_addr_lo (ld_addr_lo),
        .aligned    (w_aligned)
    );

    // Per-source final value: MEM goes through the aligner, PC becomes the
    // link address, every other source passes straight through.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
            if (gi == WDSEL_MEM) begin : g_mem
                assign w_src_fin[gi] = w_aligned;
            end else if (gi == WDSEL_PC) begin : g_pc
                assign w_src_fin[gi] = src_data[gi*DW +: DW] + DW'(LINK_OFFSET);
            end else begin : g_pass
                assign w_src_fin[gi] = src_data[gi*DW +: DW];
            end
        end
    endgenerate

    // Source mux; an out-of-range select matches nothing, giving data 0
    // and suppressing the write.
    always_comb begin
        w_sel_data = '0;
        w_sel_ok   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wd_sel == SEL_W'(i)) begin
                w_sel_data = w_src_fin[i];
                w_sel_ok   = 1'b1;
            end
        end
    end

    // Flush overrides stall, so a flushed register is never "held".
    assign w_capture = in_valid && !wb_stall && !flush;
    assign w_hold    = wb_stall && !flush;

    // WB pipeline register and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_we    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_cnt   <= '0;
        end else begin
            // An instruction retires on the edge it leaves the register.
            if (r_valid && !w_hold) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_capture) begin
                r_valid <= 1'b1;
                r_we    <= rf_we_in && (rd != '0) && w_sel_ok;
                r_waddr <= rd;
                r_wdata <= w_sel_data;
            end else if (!w_hold) begin
                // Bubble: address and data keep their last values.
                r_valid <= 1'b0;
                r_we    <= 1'b0;
            end
        end
    end

    assign in_ready   = !wb_stall;
    assign rf_we      = r_we;
    assign rf_waddr   = r_waddr;
    assign rf_wdata   = r_wdata;
    assign fwd_valid  = r_we;
    assign fwd_rd     = r_waddr;
    assign fwd_data   = r_wdata;
    assign retire_cnt = r_cnt;

endmodule

// File: tb/tb_wb_select_stage.sv
// Directed testbench for wb_select_stage: default instance plus a
// NUM_SRC=3 instance (out-of-range select) and a CNT_W=4 instance (wrap).
module tb_wb_select_stage;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         wb_stall = 1'b0;
    logic         flush = 1'b0;
    logic [1:0]   wd_sel = 2'd0;
    logic [127:0] src_data = '0;
    logic [2:0]   ld_type = 3'd0;
    logic [1:0]   ld_addr_lo = 2'd0;
    logic [4:0]   rd = 5'd0;
    logic         rf_we_in = 1'b0;

    logic         in_ready, rf_we, fwd_valid;
    logic [4:0]   rf_waddr, fwd_rd;
    logic [31:0]  rf_wdata, fwd_data, retire_cnt;

    logic         in_ready3, rf_we3, fwd_valid3;
    logic [4:0]   rf_waddr3, fwd_rd3;
    logic [31:0]  rf_wdata3, fwd_data3, retire_cnt3;

    logic         in_ready4, rf_we4, fwd_valid4;
    logic [4:0]   rf_waddr4, fwd_rd4;
    logic [31:0]  rf_wdata4, fwd_data4;
    logic [3:0]   retire_cnt4;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    wb_select_stage u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .wb_stall(wb_stall), .flush(flush), .wd_sel(wd_sel), .src_data(src_data),
        .ld_type(ld_type), .ld_addr_lo(ld_addr_lo), .rd(rd), .rf_we_in(rf_we_in),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
        .retire_cnt(retire_cnt)
    );

    wb_select_stage #(.NUM_SRC(3)) u_dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready3),
        .wb_stall(wb_stall), .flush(flush), .wd_sel(wd_sel), .src_data(src_data[95:0]),
        .ld_type(ld_type), .ld_addr_lo(ld_addr_lo), .rd(rd), .rf_we_in(rf_we_in),
        .rf_we(rf_we3), .rf_waddr(rf_waddr3), .rf_wdata(rf_wdata3),
        .fwd_valid(fwd_valid3), .fwd_rd(fwd_rd3), .fwd_data(fwd_data3),
        .retire_cnt(retire_cnt3)
    );

    wb_select_stage #(.CNT_W(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
        .wb_stall(wb_stall), .flush(flush), .wd_sel(wd_sel), .src_data(src_data),
        .ld_type(ld_type), .ld_addr_lo(ld_addr_lo), .rd(rd), .rf_we_in(rf_we_in),
        .rf_we(rf_we4), .rf_waddr(rf_waddr4), .rf_wdata(rf_wdata4),
        .fwd_valid(fwd_valid4), .fwd_rd(fwd_rd4), .fwd_data(fwd_data4),
        .retire_cnt(retire_cnt4)
    );

    // Advance one cycle; inputs change and outputs are sampled 1 time unit
    // after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; wb_stall = 1'b0; flush = 1'b0;
        step();
        rst = 1'b0;
    endtask

    // Present one instruction for a single capture edge.
    task automatic send(input logic [1:0] sel, input logic [31:0] val,
                        input logic [2:0] lt, input logic [1:0] lo,
                        input logic [4:0] r, input logic we);
        wd_sel = sel;
        src_data[sel*32 +: 32] = val;
        ld_type = lt; ld_addr_lo = lo; rd = r; rf_we_in = we;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        $display("txn sel=%0d src=%08h ld=%0d lo=%0d rd=%0d -> we=%0b waddr=%0d wdata=%08h cnt=%0d",
                 sel, val, lt, lo, r, rf_we, rf_waddr, rf_wdata, retire_cnt);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %0b want 1", in_ready); fails++;
        end
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || retire_cnt !== 32'd0) begin
            $display("FAIL reset_state: we=%0b waddr=%0d wdata=%08h cnt=%0d want all 0",
                     rf_we, rf_waddr, rf_wdata, retire_cnt); fails++;
        end
        rst = 1'b0;
        $display("txn reset done");
    endtask

    task automatic test_alu();
        do_reset();
        send(2'd0, 32'h1234_5678, 3'd0, 2'd0, 5'd5, 1'b1);
        checks++;
        if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
            $display("FAIL alu_write: we=%0b waddr=%0d wdata=%08h want 1/5/12345678",
                     rf_we, rf_waddr, rf_wdata); fails++;
        end
        checks++;
        if (fwd_valid !== 1'b1 || fwd_rd !== 5'd5 || fwd_data !== 32'h1234_5678) begin
            $display("FAIL alu_fwd: v=%0b rd=%0d data=%08h want 1/5/12345678",
                     fwd_valid, fwd_rd, fwd_data); fails++;
        end
        checks++;
        if (retire_cnt !== 32'd0) begin
            $display("FAIL alu_cnt_before: got %0d want 0", retire_cnt); fails++;
        end
        step();
        checks++;
        if (retire_cnt !== 32'd1) begin
            $display("FAIL alu_cnt_after: got %0d want 1", retire_cnt); fails++;
        end
        checks++;
        if (rf_we !== 1'b0 || rf_wdata !== 32'h1234_5678) begin
            $display("FAIL alu_bubble: we=%0b wdata=%08h want 0/12345678", rf_we, rf_wdata); fails++;
        end
    endtask

    task automatic test_load_align();
        logic [2:0]  lt  [6] = '{3'd1, 3'd3, 3'd2, 3'd4, 3'd0, 3'd7};
        logic [1:0]  lo  [6] = '{2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd3};
        logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_00FF, 32'hFFFF_80FF,
                                 32'h0000_7F01, 32'h80FF_7F01, 32'h80FF_7F01};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            send(2'd1, 32'h80FF_7F01, lt[i], lo[i], 5'd3, 1'b1);
            checks++;
            if (rf_wdata !== exp[i] || rf_we !== 1'b1) begin
                $display("FAIL load_align[%0d]: ld=%0d lo=%0d wdata=%08h we=%0b want %08h/1",
                         i, lt[i], lo[i], rf_wdata, rf_we, exp[i]); fails++;
            end
        end
    endtask

    task automatic test_link();
        do_reset();
        send(2'd2, 32'h1C00_0FFC, 3'd0, 2'd0, 5'd1, 1'b1);
        checks++;
        if (rf_wdata !== 32'h1C00_1000) begin
            $display("FAIL link_add: got %08h want 1c001000", rf_wdata); fails++;
        end
        send(2'd2, 32'hFFFF_FFFC, 3'd0, 2'd0, 5'd1, 1'b1);
        checks++;
        if (rf_wdata !== 32'h0000_0000) begin
            $display("FAIL link_wrap: got %08h want 00000000", rf_wdata); fails++;
        end
    endtask

    task automatic test_r0_invalid();
        do_reset();
        send(2'd0, 32'hAAAA_5555, 3'd0, 2'd0, 5'd0, 1'b1);
        checks++;
        if (rf_we !== 1'b0 || fwd_valid !== 1'b0) begin
            $display("FAIL r0_we: we=%0b fwd_valid=%0b want 0/0", rf_we, fwd_valid); fails++;
        end
        step();
        checks++;
        if (retire_cnt !== 32'd1) begin
            $display("FAIL r0_cnt: got %0d want 1", retire_cnt); fails++;
        end
        // Index 3 is a valid pass-through source at NUM_SRC=4, out of range at 3.
        send(2'd3, 32'h0BAD_F00D, 3'd0, 2'd0, 5'd9, 1'b1);
        checks++;
        if (rf_we !== 1'b1 || rf_wdata !== 32'h0BAD_F00D) begin
            $display("FAIL csr_pass: we=%0b wdata=%08h want 1/0badf00d", rf_we, rf_wdata); fails++;
        end
        checks++;
        if (rf_we3 !== 1'b0 || rf_wdata3 !== 32'd0) begin
            $display("FAIL bad_sel: we=%0b wdata=%08h want 0/00000000", rf_we3, rf_wdata3); fails++;
        end
    endtask

    task automatic test_stall_flush();
        do_reset();
        send(2'd0, 32'hCAFE_0007, 3'd0, 2'd0, 5'd7, 1'b1);
        // A different instruction waits at the input while WB is stalled.
        wb_stall = 1'b1; in_valid = 1'b1; rd = 5'd9; src_data[31:0] = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            $display("FAIL stall_ready: got %0b want 0", in_ready); fails++;
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hCAFE_0007 || retire_cnt !== 32'd0) begin
                $display("FAIL stall_hold[%0d]: we=%0b waddr=%0d wdata=%08h cnt=%0d want 1/7/cafe0007/0",
                         i, rf_we, rf_waddr, rf_wdata, retire_cnt); fails++;
            end
        end
        flush = 1'b1;
        step();
        $display("txn flush under stall -> we=%0b cnt=%0d", rf_we, retire_cnt);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd7 || retire_cnt !== 32'd1) begin
            $display("FAIL stall_flush: we=%0b waddr=%0d cnt=%0d want 0/7/1", rf_we, rf_waddr, retire_cnt); fails++;
        end
        // Flush without stall kills the instruction being captured.
        wb_stall = 1'b0;
        step();
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rf_wdata !== 32'hCAFE_0007 || retire_cnt !== 32'd1) begin
            $display("FAIL flush_capture: we=%0b wdata=%08h cnt=%0d want 0/cafe0007/1",
                     rf_we, rf_wdata, retire_cnt); fails++;
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send(2'd0, 32'h0000_00AB, 3'd0, 2'd0, 5'd4, 1'b1);
        wb_stall = 1'b1;
        step();
        step();
        rst = 1'b1;
        step();
        $display("txn reset under stall -> we=%0b cnt=%0d", rf_we, retire_cnt);
        checks++;
        if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0 || retire_cnt !== 32'd0) begin
            $display("FAIL reset_mid: we=%0b waddr=%0d wdata=%08h cnt=%0d want all 0",
                     rf_we, rf_waddr, rf_wdata, retire_cnt); fails++;
        end
        rst = 1'b0; wb_stall = 1'b0;
        step();
        checks++;
        if (retire_cnt !== 32'd0) begin
            $display("FAIL reset_mid_discard: cnt=%0d want 0", retire_cnt); fails++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wd_sel = 2'd0; rf_we_in = 1'b1; ld_type = 3'd0;
        for (int i = 0; i < 16; i++) begin
            src_data[31:0] = 32'h1000_0000 + 32'(i);
            rd = 5'(i + 1);
            in_valid = 1'b1;
            step();
            checks++;
            if (rf_wdata !== 32'h1000_0000 + 32'(i) || rf_waddr !== 5'(i + 1) || rf_we !== 1'b1) begin
                $display("FAIL b2b_data[%0d]: wdata=%08h waddr=%0d we=%0b want %08h/%0d/1",
                         i, rf_wdata, rf_waddr, rf_we, 32'h1000_0000 + 32'(i), i + 1); fails++;
            end
        end
        checks++;
        if (retire_cnt4 !== 4'd15) begin
            $display("FAIL cnt4_pre_wrap: got %0d want 15", retire_cnt4); fails++;
        end
        in_valid = 1'b0;
        step();
        $display("txn 16 retired -> cnt=%0d cnt4=%0d", retire_cnt, retire_cnt4);
        checks++;
        if (retire_cnt4 !== 4'd0) begin
            $display("FAIL cnt4_wrap: got %0d want 0", retire_cnt4); fails++;
        end
        checks++;
        if (retire_cnt !== 32'd16) begin
            $display("FAIL cnt_16: got %0d want 16", retire_cnt); fails++;
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_alu();
        test_load_align();
        test_link();
        test_r0_invalid();
        test_stall_flush();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
